ch_state_machine: RTL and testbench
===================================

// Module: ch_state_machine
// PURPOSE
//  Per-channel sampling controller. Sequences INIT -> SAMPLING_* -> STOPPED -> READOUT -> INIT and drives
//  current_state (types_pkg::state_t) straight into the channel trigger decoder, which converts it into
//  the active-low buffer triggers. Adds a minimum-fill guard before a stop trigger is honoured, plus a
//  programmable post-trigger stop delay.
// PARAMETERS
//  MIN_FILL    16  cycles the sampling state must be held before a stop trigger can be accepted
//  DLY_W       8   width of the stop_delay input and of the post-trigger delay counter
// PORTS
//  clk          in   1       system clock
//  rstn         in   1       synchronous, active-low reset
//  mode         in   3       sampling config: 0 A, 1 B, 2 C, 3 D, 4 E, 5 A_AND_B, 6 C_AND_D, 7 ALL
//  start        in   1       begin sampling; honoured only in INIT
//  trig_in      in   1       stop trigger, level or pulse, sampled each cycle
//  stop_delay   in   DLY_W   post-trigger cycles before STOPPED; latched when the trigger is accepted
//  rd_req       in   1       readout requested by the serializer; honoured only in STOPPED
//  rd_done      in   1       readout finished; honoured only in READOUT
//  abort        in   1       forces INIT from any state
//  current_state out state_t FSM state, registered
//  sampling     out  1       1 in any STATE_SAMPLING_* state
//  stopped      out  1       1 in STATE_STOPPED
//  trig_ack     out  1       one-cycle pulse on the cycle after the trigger is accepted
// BEHAVIOUR
//  Reset (rstn=0 at a clk edge)
//   - current_state=STATE_INIT.
//   - sampling=0, stopped=0, trig_ack=0.
//   - fill_cnt, delay_cnt, trig_pend and dly_active are all cleared.
//  Priority, highest first: rstn, abort, then normal transitions.
//   - abort=1 gives INIT on the next cycle from any state and clears all counters and flags.
//  INIT
//   - start=1: go to the sampling state selected by mode; mode is latched here and later changes are ignored.
//   - fill_cnt is cleared on entry.
//  SAMPLING_*
//   - fill_cnt increments each cycle and saturates at MIN_FILL.
//   - fill_done = (fill_cnt==MIN_FILL).
//   - trig_in=1 while !fill_done sets trig_pend; the trigger is remembered, not dropped.
//   - Accept when fill_done & (trig_in | trig_pend) & !dly_active, at cycle T:
//       - clear trig_pend; trig_ack=1 at T+1.
//       - stop_delay==0: current_state=STOPPED at T+1.
//       - otherwise load delay_cnt=stop_delay and set dly_active; the state stays in SAMPLING_*.
//   - While dly_active: delay_cnt decrements by 1 per cycle; the cycle it reaches 0, the next state is STOPPED.
//     Net effect: STOPPED at T+1+stop_delay.
//   - Further trig_in during dly_active is ignored.
//  STOPPED
//   - rd_req=1: go to READOUT next cycle.
//   - Holds indefinitely otherwise.
//  READOUT
//   - rd_done=1: go to INIT next cycle.
//  Ignored inputs
//   - start outside INIT; trig_in outside SAMPLING_*; rd_req outside STOPPED; rd_done outside READOUT.
//  Illegal or unencoded current_state: go to INIT next cycle.
//  Output timing
//   - sampling and stopped are decoded from the registered state, so they are glitch-free.
//   - Latency from input to current_state is 1 cycle.
//  Arithmetic
//   - delay_cnt is DLY_W bits and never underflows: decrement is gated by delay_cnt!=0.
//   - fill_cnt width is $clog2(MIN_FILL+1).
// STRUCTURE
//  types_pkg
//   - state_t is reused unchanged.
//   - Add mode_t (3-bit enum MODE_A..MODE_ALL) and a function mode_to_state(mode_t) returning state_t.
//  Sub-module ch_stop_delay_ctr (load/decrement/zero flag, DLY_W param) holds the post-trigger counter.
//  The FSM stays in this file.
// TESTING
//  1. Reset and start
//     - rstn=0 for 2 cycles -> current_state=INIT, sampling=0, stopped=0, trig_ack=0.
//     - mode=5, start -> SAMPLING_A_AND_B next cycle.
//  2. Early trigger
//     - mode=7, start; trig_in pulse at sampling cycle 3 with MIN_FILL=16, stop_delay=0.
//     - Required: trig_pend set; trig_ack and STOPPED exactly one cycle after fill_cnt hits 16.
//  3. Stop delay
//     - fill complete, stop_delay=5, trig_in at cycle T -> trig_ack at T+1, STOPPED at T+6.
//     - Extra trig_in at T+2 has no effect.
//  4. Readout handshake
//     - In STOPPED, rd_done=1 alone -> no change.
//     - rd_req -> READOUT; rd_done -> INIT; start in READOUT is ignored.
//  5. Abort mid-delay
//     - stop_delay=200, trigger accepted, abort at T+50 -> INIT at T+51, delay_cnt=0.
//     - A new start resamples with fill_cnt=0.
//  6. Simultaneous events
//     - abort and trig_in in the same cycle -> INIT, no trig_ack.
//     - start with mode=4 -> SAMPLING_E; stop_delay=255 -> STOPPED at T+256.

Source files
------------

// File: rtl/types_pkg.sv
// Shared channel types: FSM state encoding, sampling mode
// and the mode-to-state mapping used by the channel FSM.
package types_pkg;

    typedef enum logic [3:0] {
        STATE_INIT             = 4'd0,
        STATE_SAMPLING_A       = 4'd1,
        STATE_SAMPLING_B       = 4'd2,
        STATE_SAMPLING_C       = 4'd3,
        STATE_SAMPLING_D       = 4'd4,
        STATE_SAMPLING_E       = 4'd5,
        STATE_SAMPLING_A_AND_B = 4'd6,
        STATE_SAMPLING_C_AND_D = 4'd7,
        STATE_SAMPLING_ALL     = 4'd8,
        STATE_STOPPED          = 4'd9,
        STATE_READOUT          = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        MODE_A       = 3'd0,
        MODE_B       = 3'd1,
        MODE_C       = 3'd2,
        MODE_D       = 3'd3,
        MODE_E       = 3'd4,
        MODE_A_AND_B = 3'd5,
        MODE_C_AND_D = 3'd6,
        MODE_ALL     = 3'd7
    } mode_t;

    function automatic state_t mode_to_state(mode_t m);
        case (m)
            MODE_A:       return STATE_SAMPLING_A;
            MODE_B:       return STATE_SAMPLING_B;
            MODE_C:       return STATE_SAMPLING_C;
            MODE_D:       return STATE_SAMPLING_D;
            MODE_E:       return STATE_SAMPLING_E;
            MODE_A_AND_B: return STATE_SAMPLING_A_AND_B;
            MODE_C_AND_D: return STATE_SAMPLING_C_AND_D;
            MODE_ALL:     return STATE_SAMPLING_ALL;
            default:      return STATE_INIT;
        endcase
    endfunction

endpackage

// File: rtl/ch_stop_delay_ctr.sv
// Post-trigger stop delay counter: clear, load, and a
// decrement that is gated so the count never wraps.
module ch_stop_delay_ctr
    import types_pkg::*;
#(
    parameter int DLY_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [DLY_W-1:0] load_val_i,
    output logic [DLY_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DLY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ch_state_machine.sv
// Per-channel sampling controller with a minimum-fill guard
// on the stop trigger and a programmable post-trigger delay.
module ch_state_machine
    import types_pkg::*;
#(
    parameter int MIN_FILL = 16,
    parameter int DLY_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic             trig_in,
    input  logic [DLY_W-1:0] stop_delay,
    input  logic             rd_req,
    input  logic             rd_done,
    input  logic             abort,
    output state_t           current_state,
    output logic             sampling,
    output logic             stopped,
    output logic             trig_ack
);

    localparam int FW = $clog2(MIN_FILL + 1);

    state_t          state_q, state_d;
    logic [FW-1:0]   fill_cnt_q, fill_cnt_d;
    logic            trig_pend_q, trig_pend_d;
    logic            dly_active_q, dly_active_d;
    logic            trig_ack_q, trig_ack_d;

    logic            dly_clr, dly_load, dly_dec;
    logic [DLY_W-1:0] dly_cnt;
    logic            dly_zero;
    logic            is_samp, fill_done, dly_last;

    ch_stop_delay_ctr #(
        .DLY_W (DLY_W)
    ) u_dly (
        .clk        (clk),
        .rstn       (rstn),
        .clr_i      (dly_clr),
        .load_i     (dly_load),
        .dec_i      (dly_dec),
        .load_val_i (stop_delay),
        .cnt_o      (dly_cnt),
        .zero_o     (dly_zero)
    );

    assign is_samp   = state_q inside {
        STATE_SAMPLING_A, STATE_SAMPLING_B, STATE_SAMPLING_C,
        STATE_SAMPLING_D, STATE_SAMPLING_E,
        STATE_SAMPLING_A_AND_B, STATE_SAMPLING_C_AND_D,
        STATE_SAMPLING_ALL};
    assign fill_done = (fill_cnt_q == FW'(MIN_FILL));
    // Count reaching zero on this edge means STOPPED next cycle
    assign dly_last  = dly_zero || (dly_cnt == DLY_W'(1));

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        trig_pend_d  = trig_pend_q;
        dly_active_d = dly_active_q;
        trig_ack_d   = 1'b0;
        dly_clr      = 1'b0;
        dly_load     = 1'b0;
        dly_dec      = 1'b0;
        if (abort) begin
            state_d      = STATE_INIT;
            fill_cnt_d   = '0;
            trig_pend_d  = 1'b0;
            dly_active_d = 1'b0;
            dly_clr      = 1'b1;
        end else begin
            unique case (state_q)
                STATE_INIT: begin
                    fill_cnt_d   = '0;
                    trig_pend_d  = 1'b0;
                    dly_active_d = 1'b0;
                    dly_clr      = 1'b1;
                    if (start) begin
                        state_d = mode_to_state(mode_t'(mode));
                    end
                end
                STATE_SAMPLING_A, STATE_SAMPLING_B,
                STATE_SAMPLING_C, STATE_SAMPLING_D,
                STATE_SAMPLING_E, STATE_SAMPLING_A_AND_B,
                STATE_SAMPLING_C_AND_D, STATE_SAMPLING_ALL: begin
                    if (!fill_done) begin
                        fill_cnt_d = fill_cnt_q + FW'(1);
                    end
                    if (dly_active_q) begin
                        dly_dec = 1'b1;
                        if (dly_last) begin
                            state_d      = STATE_STOPPED;
                            dly_active_d = 1'b0;
                        end
                    end else if (fill_done && (trig_in || trig_pend_q)) begin
                        trig_pend_d = 1'b0;
                        trig_ack_d  = 1'b1;
                        if (stop_delay == '0) begin
                            state_d = STATE_STOPPED;
                        end else begin
                            dly_load     = 1'b1;
                            dly_active_d = 1'b1;
                        end
                    end else if (trig_in && !fill_done) begin
                        trig_pend_d = 1'b1;
                    end
                end
                STATE_STOPPED: begin
                    if (rd_req) begin
                        state_d = STATE_READOUT;
                    end
                end
                STATE_READOUT: begin
                    if (rd_done) begin
                        state_d = STATE_INIT;
                    end
                end
                default: begin
                    state_d = STATE_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= STATE_INIT;
            fill_cnt_q   <= '0;
            trig_pend_q  <= 1'b0;
            dly_active_q <= 1'b0;
            trig_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            trig_pend_q  <= trig_pend_d;
            dly_active_q <= dly_active_d;
            trig_ack_q   <= trig_ack_d;
        end
    end

    assign current_state = state_q;
    assign sampling      = is_samp;
    assign stopped       = (state_q == STATE_STOPPED);
    assign trig_ack      = trig_ack_q;

endmodule

// File: tb/tb_ch_state_machine.sv
// Directed bench for ch_state_machine: reset, fill guard,
// stop delay, readout handshake, abort and event collisions.
module tb_ch_state_machine;
    import types_pkg::*;

    logic       clk = 1'b0;
    logic       rstn, start, trig_in, rd_req, rd_done, abort;
    logic [2:0] mode;
    logic [7:0] stop_delay;
    state_t     cur;
    logic       sampling, stopped, trig_ack;

    int n_chk  = 0;
    int n_fail = 0;

    ch_state_machine #(
        .MIN_FILL (16),
        .DLY_W    (8)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .mode          (mode),
        .start         (start),
        .trig_in       (trig_in),
        .stop_delay    (stop_delay),
        .rd_req        (rd_req),
        .rd_done       (rd_done),
        .abort         (abort),
        .current_state (cur),
        .sampling      (sampling),
        .stopped       (stopped),
        .trig_ack      (trig_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; trig_in = 1'b0;
        rd_req = 1'b0; rd_done = 1'b0; abort = 1'b0;
        mode = 3'd0; stop_delay = 8'd0;

        // 1. reset and start
        tick(2);
        chk("rst_state", 32'(cur), 32'(STATE_INIT));
        chk("rst_samp", 32'(sampling), 0);
        chk("rst_stop", 32'(stopped), 0);
        chk("rst_ack", 32'(trig_ack), 0);
        rstn = 1'b1;
        mode = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ab", 32'(cur), 32'(STATE_SAMPLING_A_AND_B));
        chk("start_samp", 32'(sampling), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort1", 32'(cur), 32'(STATE_INIT));

        // 2. early trigger remembered until fill completes
        mode = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        mode = 3'd0;
        chk("all_state", 32'(cur), 32'(STATE_SAMPLING_ALL));
        tick(3);
        trig_in = 1'b1; tick(); trig_in = 1'b0;
        chk("pend_set", 32'(dut.trig_pend_q), 1);
        chk("early_ack", 32'(trig_ack), 0);
        tick(12);
        chk("fill16", 32'(dut.fill_cnt_q), 16);
        chk("pre_stop", 32'(cur), 32'(STATE_SAMPLING_ALL));
        tick();
        chk("early_stop", 32'(cur), 32'(STATE_STOPPED));
        chk("early_ack1", 32'(trig_ack), 1);
        chk("stopped_o", 32'(stopped), 1);
        tick();
        chk("ack_pulse", 32'(trig_ack), 0);

        // 4. readout handshake
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        chk("done_in_stop", 32'(cur), 32'(STATE_STOPPED));
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        chk("readout", 32'(cur), 32'(STATE_READOUT));
        start = 1'b1; tick(); start = 1'b0;
        chk("start_in_rd", 32'(cur), 32'(STATE_READOUT));
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        chk("rd_to_init", 32'(cur), 32'(STATE_INIT));

        // 3. stop delay of 5
        mode = 3'd0; start = 1'b1; tick(); start = 1'b0;
        chk("a_state", 32'(cur), 32'(STATE_SAMPLING_A));
        tick(16);
        stop_delay = 8'd5; trig_in = 1'b1;
        tick();
        trig_in = 1'b0; stop_delay = 8'd0;
        chk("dly_ack", 32'(trig_ack), 1);
        chk("dly_hold", 32'(cur), 32'(STATE_SAMPLING_A));
        tick();
        trig_in = 1'b1; tick(); trig_in = 1'b0;
        chk("extra_trig", 32'(trig_ack), 0);
        tick(2);
        chk("dly_t5", 32'(cur), 32'(STATE_SAMPLING_A));
        tick();
        chk("dly_t6", 32'(cur), 32'(STATE_STOPPED));
        abort = 1'b1; tick(); abort = 1'b0;

        // 5. abort in the middle of a long delay
        mode = 3'd2; start = 1'b1; tick(); start = 1'b0;
        tick(16);
        stop_delay = 8'd200; trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        chk("long_ack", 32'(trig_ack), 1);
        tick(49);
        chk("t50_state", 32'(cur), 32'(STATE_SAMPLING_C));
        chk("t50_cnt", 32'(dut.u_dly.cnt_q), 151);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_init", 32'(cur), 32'(STATE_INIT));
        chk("abort_cnt", 32'(dut.u_dly.cnt_q), 0);
        chk("abort_act", 32'(dut.dly_active_q), 0);
        mode = 3'd3; start = 1'b1; tick(); start = 1'b0;
        chk("resample", 32'(cur), 32'(STATE_SAMPLING_D));
        chk("fill0", 32'(dut.fill_cnt_q), 0);

        // 6. abort collides with an acceptable trigger
        tick(16);
        abort = 1'b1; trig_in = 1'b1; tick();
        abort = 1'b0; trig_in = 1'b0;
        chk("coll_init", 32'(cur), 32'(STATE_INIT));
        chk("coll_ack", 32'(trig_ack), 0);
        tick();
        chk("coll_ack2", 32'(trig_ack), 0);
        mode = 3'd4; start = 1'b1; tick(); start = 1'b0;
        chk("e_state", 32'(cur), 32'(STATE_SAMPLING_E));
        tick(16);
        stop_delay = 8'd255; trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        chk("max_ack", 32'(trig_ack), 1);
        tick(254);
        chk("max_t255", 32'(cur), 32'(STATE_SAMPLING_E));
        tick();
        chk("max_t256", 32'(cur), 32'(STATE_STOPPED));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
